// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between a byte source and the UART transmitter.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       tx_data_out;
    logic       tx_busy;
    logic       tx_done;

    // Byte source: requests frames and observes line/status
    modport master (
        output tx_start,
        output tx_data_in,
        input  tx_data_out,
        input  tx_busy,
        input  tx_done
    );

    // Transmitter: accepts requests and drives line/status
    modport slave (
        input  tx_start,
        input  tx_data_in,
        output tx_data_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Every bit lasts CLKS_PER_BIT clocks; line, busy and done are registered.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 3,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [7:0]       shreg_q, shreg_n;
    logic             line_q, line_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             bit_end;
    logic             parity_bit;

    assign bus.tx_data_out = line_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_done     = done_q;

    // State, counters, latched byte and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shreg_q <= shreg_n;
            line_q  <= line_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next state and next registered outputs, derived from the upcoming state
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        idx_n      = idx_q;
        shreg_n    = shreg_q;
        line_n     = 1'b1;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        bit_end    = (cnt_q == CNT_LAST);
        parity_bit = (^shreg_q) ^ (PARITY_ODD != 0);

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    state_n = START;
                    shreg_n = bus.tx_data_in;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shreg_n[idx_n];
            PARITY:  line_n = parity_bit;
            default: line_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
    end

endmodule
